// File: rtl/mmio_job_arbiter.sv
// Round-robin job scheduler in front of a single mini RV32I core: grants one
// requester, latches its operands onto the core MMIO inputs, lets the core run
// until EBREAK (or a cycle budget expires), then returns the result to the owner.
module mmio_job_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_res,
    output logic                 rsp_err,
    output logic                 core_rst,
    output logic [31:0]          core_in_a,
    output logic [31:0]          core_in_b,
    output logic [1:0]           core_op,
    input  logic [31:0]          core_out_res,
    input  logic                 core_out_valid,
    input  logic                 core_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     jobs_done
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t           state, state_nxt;
    logic [RR_W-1:0]  rr;
    logic [RR_W-1:0]  owner;
    logic [RR_W-1:0]  winner;
    logic             any_valid;
    logic [TO_W-1:0]  cnt;

    // Round-robin search starting just after the last winner; the descending
    // loop leaves the closest requester (highest priority) as the final pick.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_valid[(int'(rr) + i) % N_REQ]) begin
                winner    = RR_W'((int'(rr) + i) % N_REQ);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state logic: RUN ends on core completion (checked first) or budget expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = RUN;
            RUN:     if (core_done || cnt == TO_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant, response strobe and core control decoded from the state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
        if (state == RESP)              rsp_valid[owner]  = 1'b1;
        core_rst = (state != RUN);
        busy     = (state != IDLE);
    end

    // Operand latch on transfer, RUN cycle budget, result capture and job count.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_in_a <= '0;
            core_in_b <= '0;
            core_op   <= '0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
            jobs_done <= '0;
            cnt       <= '0;
            rr        <= RR_LAST;
            owner     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        core_in_a <= req_a[32*int'(winner) +: 32];
                        core_in_b <= req_b[32*int'(winner) +: 32];
                        core_op   <= req_op[2*int'(winner) +: 2];
                        owner     <= winner;
                        rr        <= winner;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + TO_W'(1);
                    if (core_done) begin
                        rsp_err <= ~core_out_valid;
                        rsp_res <= core_out_valid ? core_out_res : 32'h0;
                    end else if (cnt == TO_LAST) begin
                        rsp_err <= 1'b1;
                        rsp_res <= 32'h0;
                    end
                end
                RESP: jobs_done <= jobs_done + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
